// File: rtl/elev_pkg.sv
// Shared constants for the SCAN elevator controller: state encoding, direction values, floor width helper.
package elev_pkg;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_MOVING_UP   = 2'd1;
  localparam logic [1:0] ST_MOVING_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR_OPEN   = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Floor index width, never below one bit.
  function automatic int floor_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/elev_tick_timer.sv
// Generic period counter: counts 0..limit-1 while enabled, wraps on the terminal count, clear has priority.
module elev_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  assign done = enable && !clear && (count == limit - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || done) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller with timed travel and door dwell.
// Optional emergency stop input and freeze logic built only when ELEV_ESTOP_EN is defined.
module elevator_scan_ctrl
  import elev_pkg::*;
#(
  parameter  int NUM_FLOORS   = 8,
  parameter  int TRAVEL_TICKS = 10000000,
  parameter  int DOOR_TICKS   = 20000000,
  localparam int FLOOR_W      = floor_width(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req_i,
  output logic [FLOOR_W-1:0]    floor_o,
  output logic                  moving_up_o,
  output logic                  moving_down_o,
  output logic                  door_open_o,
  output logic                  idle_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic [1:0]            state_o
`ifdef ELEV_ESTOP_EN
  ,
  input  logic                  estop_i
`endif
);

  localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]         TRAVEL_L = TW'(TRAVEL_TICKS);
  localparam logic [TW-1:0]         DOOR_L   = TW'(DOOR_TICKS);
  localparam logic [NUM_FLOORS-1:0] ONE_HOT  = NUM_FLOORS'(1);
  localparam logic [FLOOR_W-1:0]    STEP     = FLOOR_W'(1);

  logic [1:0]            state, state_n;
  logic [FLOOR_W-1:0]    floor_n;
  logic                  dir_r, dir_n;
  logic [NUM_FLOORS-1:0] req_q, pend_all, pending_n, served;
  logic [NUM_FLOORS-1:0] above_mask, below_mask;
  logic                  above, below, ahead, behind;
  logic                  t_clear, t_enable, t_done;
  logic [TW-1:0]         t_limit;
  logic                  freeze;

`ifdef ELEV_ESTOP_EN
  assign freeze = estop_i;
`else
  assign freeze = 1'b0;
`endif

  assign state_o = state;

  // Requests pass through one input register before any decision uses them.
  assign pend_all = pending_o | req_q;

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (i > int'(floor_o));
      below_mask[i] = (i < int'(floor_o));
    end
  end

  assign above  = |(pend_all & above_mask);
  assign below  = |(pend_all & below_mask);
  assign ahead  = (dir_r == DIR_UP) ? above : below;
  assign behind = (dir_r == DIR_UP) ? below : above;

  always_comb begin
    state_n  = state;
    floor_n  = floor_o;
    dir_n    = dir_r;
    t_clear  = 1'b0;
    t_enable = 1'b0;
    t_limit  = TRAVEL_L;
    served   = '0;
    if (!freeze) begin
      case (state)
        ST_IDLE: begin
          t_clear = 1'b1;
          if (pend_all[floor_o]) begin
            state_n = ST_DOOR_OPEN;
          end else if (above && below) begin
            state_n = (dir_r == DIR_UP) ? ST_MOVING_UP : ST_MOVING_DOWN;
          end else if (above) begin
            state_n = ST_MOVING_UP;
          end else if (below) begin
            state_n = ST_MOVING_DOWN;
          end
        end
        ST_MOVING_UP, ST_MOVING_DOWN: begin
          t_enable = 1'b1;
          t_limit  = TRAVEL_L;
          if (t_done) begin
            floor_n = (state == ST_MOVING_UP) ? floor_o + STEP : floor_o - STEP;
            if (pend_all[floor_n]) state_n = ST_DOOR_OPEN;
          end
        end
        default: begin
          t_enable = 1'b1;
          t_limit  = DOOR_L;
          // A fresh call for this floor keeps the door open for a full dwell.
          if (req_q[floor_o]) begin
            t_clear = 1'b1;
          end else if (t_done) begin
            if (ahead)       state_n = (dir_r == DIR_UP) ? ST_MOVING_UP : ST_MOVING_DOWN;
            else if (behind) state_n = (dir_r == DIR_UP) ? ST_MOVING_DOWN : ST_MOVING_UP;
            else             state_n = ST_IDLE;
          end
        end
      endcase
    end
    if (state_n == ST_MOVING_UP)        dir_n = DIR_UP;
    else if (state_n == ST_MOVING_DOWN) dir_n = DIR_DOWN;
    if (state_n == ST_DOOR_OPEN) served = ONE_HOT << floor_n;
  end

  assign pending_n = pend_all & ~served;

  elev_tick_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clear),
    .enable (t_enable),
    .limit  (t_limit),
    .done   (t_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q         <= '0;
      pending_o     <= '0;
      state         <= ST_IDLE;
      floor_o       <= '0;
      dir_r         <= DIR_UP;
      idle_o        <= 1'b1;
      moving_up_o   <= 1'b0;
      moving_down_o <= 1'b0;
      door_open_o   <= 1'b0;
    end else begin
      req_q     <= req_i;
      pending_o <= pending_n;
      state     <= state_n;
      floor_o   <= floor_n;
      dir_r     <= dir_n;
      if (!freeze) begin
        idle_o        <= (state_n == ST_IDLE) && (pending_n == '0);
        moving_up_o   <= (state_n == ST_MOVING_UP);
        moving_down_o <= (state_n == ST_MOVING_DOWN);
        door_open_o   <= (state_n == ST_DOOR_OPEN);
      end
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl with NUM_FLOORS=8, TRAVEL_TICKS=4, DOOR_TICKS=3.
// Build with ELEV_ESTOP_EN defined to include the emergency-stop scenario.
module tb_elevator_scan_ctrl;

  localparam logic [3:0] F_IDLE = 4'b1000;
  localparam logic [3:0] F_UP   = 4'b0100;
  localparam logic [3:0] F_DOWN = 4'b0010;
  localparam logic [3:0] F_DOOR = 4'b0001;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req   = '0;
  logic [2:0] floor;
  logic       up, down, door, idle;
  logic [7:0] pending;
  logic [1:0] state;
`ifdef ELEV_ESTOP_EN
  logic       estop = 1'b0;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  elevator_scan_ctrl #(
    .NUM_FLOORS   (8),
    .TRAVEL_TICKS (4),
    .DOOR_TICKS   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_i         (req),
    .floor_o       (floor),
    .moving_up_o   (up),
    .moving_down_o (down),
    .door_open_o   (door),
    .idle_o        (idle),
    .pending_o     (pending),
    .state_o       (state)
`ifdef ELEV_ESTOP_EN
    ,
    .estop_i       (estop)
`endif
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // floor plus {idle, up, down, door}
  task automatic st(input string tag, input logic [2:0] f, input logic [3:0] flags);
    chk(tag, {25'd0, floor, idle, up, down, door}, {25'd0, f, flags});
  endtask

  task automatic pulse(input logic [7:0] r);
    req = r;
    tick(1);
    req = '0;
  endtask

  initial begin
    tick(2);
    st("rst_outputs", 3'd0, F_IDLE);
    chk("rst_pending", pending, 8'h00);
    chk("rst_state", state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);

    // single request two floors up
    pulse(8'h04);
    st("t1_latch", 3'd0, F_IDLE);
    tick(1);
    st("t1_depart", 3'd0, F_UP);
    chk("t1_pend", pending, 8'h04);
    chk("t1_state", state, 2'd1);
    tick(3);
    st("t1_before_f1", 3'd0, F_UP);
    tick(1);
    st("t1_floor1", 3'd1, F_UP);
    tick(4);
    st("t1_floor2", 3'd2, F_DOOR);
    chk("t1_pend_clr", pending, 8'h00);
    tick(2);
    st("t1_dwell_end", 3'd2, F_DOOR);
    tick(1);
    st("t1_idle", 3'd2, F_IDLE);

    // requests above and below; previous motion was up
    pulse(8'h41);
    tick(1);
    st("t2_pref_up", 3'd2, F_UP);
    chk("t2_pend", pending, 8'h41);
    tick(16);
    st("t2_floor6", 3'd6, F_DOOR);
    chk("t2_pend6", pending, 8'h01);
    tick(3);
    st("t2_reverse", 3'd6, F_DOWN);
    tick(24);
    st("t2_floor0", 3'd0, F_DOOR);
    chk("t2_pend0", pending, 8'h00);
    tick(3);
    st("t2_idle", 3'd0, F_IDLE);

    // intermediate request picked up on the way
    pulse(8'h20);
    tick(1);
    st("t3_depart", 3'd0, F_UP);
    tick(6);
    pulse(8'h08);
    tick(1);
    st("t3_floor2", 3'd2, F_UP);
    chk("t3_pend", pending, 8'h28);
    tick(4);
    st("t3_floor3", 3'd3, F_DOOR);
    chk("t3_pend3", pending, 8'h20);
    tick(3);
    st("t3_continue", 3'd3, F_UP);
    tick(8);
    st("t3_floor5", 3'd5, F_DOOR);
    tick(3);
    st("t3_idle", 3'd5, F_IDLE);

    // hall call held at the open floor
    pulse(8'h10);
    tick(1);
    st("t4_depart", 3'd5, F_DOWN);
    tick(4);
    st("t4_floor4", 3'd4, F_DOOR);
    req = 8'h10;
    tick(5);
    st("t4_held", 3'd4, F_DOOR);
    chk("t4_pend_held", pending, 8'h00);
    req = '0;
    tick(3);
    st("t4_tail", 3'd4, F_DOOR);
    chk("t4_pend_tail", pending, 8'h00);
    tick(1);
    st("t4_idle", 3'd4, F_IDLE);

    // reset while travelling from 3 toward 4
    pulse(8'h04);
    tick(9);
    st("t5_floor2", 3'd2, F_DOOR);
    tick(3);
    st("t5_idle2", 3'd2, F_IDLE);
    pulse(8'h80);
    tick(5);
    st("t5_floor3", 3'd3, F_UP);
    tick(2);
    st("t5_mid", 3'd3, F_UP);
    chk("t5_pend_mid", pending, 8'h80);
    #2 reset = 1'b1;
    #1;
    st("t5_async", 3'd0, F_IDLE);
    chk("t5_pend_rst", pending, 8'h00);
    chk("t5_state_rst", state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(10);
    st("t5_stays", 3'd0, F_IDLE);
    chk("t5_pend_after", pending, 8'h00);

`ifdef ELEV_ESTOP_EN
    // ten-cycle freeze one cycle into the first leg
    pulse(8'h04);
    tick(2);
    estop = 1'b1;
    tick(10);
    st("t6_frozen", 3'd0, F_UP);
    chk("t6_state", state, 2'd1);
    chk("t6_pend", pending, 8'h04);
    estop = 1'b0;
    tick(2);
    st("t6_resume", 3'd0, F_UP);
    tick(1);
    st("t6_floor1", 3'd1, F_UP);
    tick(4);
    st("t6_floor2", 3'd2, F_DOOR);
    tick(3);
    st("t6_idle", 3'd2, F_IDLE);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
